// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style execute stage: ALU opcodes, shifter codes,
// NZCV bit positions, forwarding selects and the multiplier FSM states.
package arm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned SO_W   = 12;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned CNT_W  = 5;

    localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_V = 0;

    localparam logic [1:0] FWD_REG0 = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_REG1 = 2'b11;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    // Rotate right; an amount of zero returns the value unchanged.
    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] v,
                                                input logic [CNT_W-1:0]  amt);
        logic [2*DATA_W-1:0] dbl;
        dbl = {v, v} >> amt;
        return dbl[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: 12-bit offset for memory access, rotated 8-bit immediate,
// or the Rm register passed through the barrel shifter.
module val2_generator
    import arm_pkg::*;
(
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic              mem_en,
    input  logic [SO_W-1:0]   shift_operand,
    output logic [DATA_W-1:0] val2
);

    logic [CNT_W-1:0] sh_amt;
    logic [CNT_W-1:0] rot_amt;

    assign sh_amt  = shift_operand[11:7];
    assign rot_amt = {shift_operand[11:8], 1'b0};

    // Select operand source and apply shift/rotate.
    always_comb begin
        val2 = val_rm;
        if (mem_en) begin
            val2 = {20'b0, shift_operand};
        end else if (imm) begin
            val2 = ror32({24'b0, shift_operand[7:0]}, rot_amt);
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = val_rm << sh_amt;
                SH_LSR:  val2 = val_rm >> sh_amt;
                SH_ASR:  val2 = 32'($signed(val_rm) >>> sh_amt);
                default: val2 = ror32(val_rm, sh_amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2, ALU, NZCV register, branch target,
// iterative shift-add multiplier with upstream stall.
// Optional feature macro: EXE_FORWARDING_EN (muxes Rn/Rm from MEM/WB forwarding paths).
module exe_stage
    import arm_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [CMD_W-1:0]  exe_cmd,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic [SO_W-1:0]   shift_operand,
    input  logic [23:0]       signed_imm_24,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [1:0]        fwd_sel1,
    input  logic [1:0]        fwd_sel2,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_val,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [REG_W-1:0]  dest,
    output logic [DATA_W-1:0] branch_addr,
    output logic              branch_taken,
    output logic [3:0]        sr_out,
    output logic              stall_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] val2;
    logic              mem_en;

    logic [3:0]        sr;
    logic [3:0]        sr_next;
    logic              sr_upd;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum;
    logic              flag_c;
    logic              flag_v;

    mul_state_e        state;
    mul_state_e        state_n;
    logic              mul_load;
    logic              mul_step;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;

`ifdef EXE_FORWARDING_EN
    // Pick Rn/Rm from the register file or a younger instruction's result.
    always_comb begin
        op_a = val_rn;
        op_b = val_rm;
        case (fwd_sel1)
            FWD_MEM: op_a = mem_fwd_val;
            FWD_WB:  op_a = wb_fwd_val;
            default: op_a = val_rn;
        endcase
        case (fwd_sel2)
            FWD_MEM: op_b = mem_fwd_val;
            FWD_WB:  op_b = wb_fwd_val;
            default: op_b = val_rm;
        endcase
    end
`else
    logic unused_fwd;
    assign op_a       = val_rn;
    assign op_b       = val_rm;
    assign unused_fwd = ^{fwd_sel1, fwd_sel2, mem_fwd_val, wb_fwd_val};
`endif

    assign mem_en = mem_r_en_in | mem_w_en_in;

    val2_generator u_val2 (
        .val_rm        (op_b),
        .imm           (imm),
        .mem_en        (mem_en),
        .shift_operand (shift_operand),
        .val2          (val2)
    );

    // ALU: result and candidate NZCV; C/V keep old values for logic ops.
    always_comb begin
        alu_res = '0;
        sum     = '0;
        flag_c  = sr[SR_C];
        flag_v  = sr[SR_V];
        sr_upd  = 1'b0;
        case (exe_cmd)
            CMD_MOV: begin alu_res = val2;          sr_upd = 1'b1; end
            CMD_MVN: begin alu_res = ~val2;         sr_upd = 1'b1; end
            CMD_AND: begin alu_res = op_a & val2;   sr_upd = 1'b1; end
            CMD_ORR: begin alu_res = op_a | val2;   sr_upd = 1'b1; end
            CMD_EOR: begin alu_res = op_a ^ val2;   sr_upd = 1'b1; end
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, op_a} + {1'b0, val2}
                    + ((exe_cmd == CMD_ADC) ? 33'(sr[SR_C]) : 33'd0);
                alu_res = sum[DATA_W-1:0];
                flag_c  = sum[DATA_W];
                flag_v  = (op_a[31] == val2[31]) && (alu_res[31] != op_a[31]);
                sr_upd  = 1'b1;
            end
            CMD_SUB, CMD_SBC: begin
                // a - b - borrow computed as a + ~b + carry_in; carry-out is NOT borrow.
                sum = {1'b0, op_a} + {1'b0, ~val2}
                    + ((exe_cmd == CMD_SBC) ? 33'(sr[SR_C]) : 33'd1);
                alu_res = sum[DATA_W-1:0];
                flag_c  = sum[DATA_W];
                flag_v  = (op_a[31] != val2[31]) && (alu_res[31] != op_a[31]);
                sr_upd  = 1'b1;
            end
            CMD_MUL: begin
                alu_res = acc;
                sr_upd  = (state == MUL_DONE);
            end
            default: begin
                alu_res = '0;
            end
        endcase
        sr_next = {alu_res[31], (alu_res == 32'd0), flag_c, flag_v};
    end

    // Status register: committed only for flag-setting instructions that are not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (s_in && !stall_out && sr_upd) begin
            sr <= sr_next;
        end
    end

    // Multiplier state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Multiplier next state and stall; stall covers the issue cycle and all BUSY cycles.
    always_comb begin
        state_n   = state;
        stall_out = 1'b0;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (exe_cmd == CMD_MUL) begin
                    stall_out = 1'b1;
                    mul_load  = 1'b1;
                    state_n   = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                stall_out = 1'b1;
                mul_step  = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_n = MUL_DONE;
                end
            end
            MUL_DONE: begin
                state_n = MUL_IDLE;
            end
            default: begin
                state_n = MUL_IDLE;
            end
        endcase
        if (rst) begin
            stall_out = 1'b0;
        end
    end

    // Shift-add datapath: operands latched on issue, one multiplier bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (mul_load) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= val2;
            cnt    <= '0;
        end else if (mul_step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign alu_result   = alu_res;
    assign st_val       = op_b;
    assign wb_en        = wb_en_in    & ~stall_out;
    assign mem_r_en     = mem_r_en_in & ~stall_out;
    assign mem_w_en     = mem_w_en_in & ~stall_out;
    assign dest         = dest_in;
    assign branch_addr  = pc_in + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
    assign branch_taken = b_in & ~stall_out;
    assign sr_out       = sr;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage (default MUL_CYCLES = 32).
module tb_exe_stage;
    import arm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [3:0]  exe_cmd;
    logic [31:0] pc_in, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest_in;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic [31:0] alu_result, st_val, branch_addr;
    logic        wb_en, mem_r_en, mem_w_en, branch_taken, stall_out;
    logic [3:0]  dest, sr_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_stall;
    logic seen_done;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .exe_cmd(exe_cmd), .pc_in(pc_in),
        .val_rn(val_rn), .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest_in(dest_in),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .alu_result(alu_result), .st_val(st_val), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .dest(dest),
        .branch_addr(branch_addr), .branch_taken(branch_taken),
        .sr_out(sr_out), .stall_out(stall_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a new instruction just after the clock edge, then move to the sampling edge.
    task automatic drive(input logic [3:0] c, input logic [31:0] rn, input logic [31:0] rm,
                         input logic im, input logic [11:0] so, input logic s);
        @(posedge clk);
        #1;
        exe_cmd       = c;
        val_rn        = rn;
        val_rm        = rm;
        imm           = im;
        shift_operand = so;
        s_in          = s;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; b_in = 1'b0; s_in = 1'b0;
        exe_cmd = CMD_MUL; pc_in = '0; val_rn = '0; val_rm = '0; imm = 1'b0;
        shift_operand = '0; signed_imm_24 = '0; dest_in = 4'd9;
        fwd_sel1 = 2'b00; fwd_sel2 = 2'b00; mem_fwd_val = '0; wb_fwd_val = '0;

        // Reset, with a MUL on the inputs: no stall while in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sr", 32'(sr_out), 32'h0);
        check("rst_stall", 32'(stall_out), 32'h0);
        check("rst_dest", 32'(dest), 32'h9);
        @(posedge clk); #1;
        exe_cmd = CMD_MOV;
        rst = 1'b0;

        // Signed overflow on ADD
        drive(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 12'h000, 1'b1);
        check("add_ovf_res", alu_result, 32'h8000_0000);
        check("add_ovf_sr_before_edge", 32'(sr_out), 32'h0);
        check("add_wb_en", 32'(wb_en), 32'h1);
        drive(CMD_SUB, 32'h5, 32'h0, 1'b1, 12'h0FF, 1'b1);
        check("add_ovf_sr", 32'(sr_out), 32'h9);
        check("sub_imm_res", alu_result, 32'hFFFF_FF06);
        drive(CMD_MOV, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0);
        check("sub_imm_sr", 32'(sr_out), 32'h8);
        check("imm_rot8", alu_result, 32'hFF00_0000);

        // Barrel shifter on Rm
        drive(CMD_MOV, 32'h0, 32'h8000_0013, 1'b0, 12'h200, 1'b0);
        check("lsl4", alu_result, 32'h0000_0130);
        check("sr_kept_s0", 32'(sr_out), 32'h8);
        drive(CMD_MOV, 32'h0, 32'h8000_0013, 1'b0, 12'h220, 1'b0);
        check("lsr4", alu_result, 32'h0800_0001);
        drive(CMD_MOV, 32'h0, 32'h8000_0013, 1'b0, 12'h240, 1'b0);
        check("asr4", alu_result, 32'hF800_0001);
        drive(CMD_MOV, 32'h0, 32'h8000_0013, 1'b0, 12'h260, 1'b0);
        check("ror4", alu_result, 32'h3800_0001);
        drive(CMD_MOV, 32'h0, 32'h8000_0013, 1'b0, 12'h060, 1'b0);
        check("ror0_identity", alu_result, 32'h8000_0013);
        drive(CMD_MVN, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        check("mvn", alu_result, 32'hFFFF_FFFF);

        // Carry-chain ops
        drive(CMD_SUB, 32'h5, 32'h3, 1'b0, 12'h000, 1'b1);
        check("sub_res", alu_result, 32'h2);
        drive(CMD_ADC, 32'h1, 32'h1, 1'b0, 12'h000, 1'b0);
        check("sub_sr_c", 32'(sr_out), 32'h2);
        check("adc_c1", alu_result, 32'h3);
        drive(CMD_SBC, 32'h5, 32'h3, 1'b0, 12'h000, 1'b0);
        check("sbc_c1", alu_result, 32'h2);
        drive(CMD_SUB, 32'h3, 32'h3, 1'b0, 12'h000, 1'b1);
        check("sub_zero", alu_result, 32'h0);
        drive(CMD_AND, 32'hF0F0, 32'hFF00, 1'b0, 12'h000, 1'b1);
        check("sub_zero_sr", 32'(sr_out), 32'h6);
        check("and", alu_result, 32'hF000);
        drive(CMD_SBC, 32'h3, 32'h5, 1'b0, 12'h000, 1'b1);
        check("and_sr_keeps_c", 32'(sr_out), 32'h2);
        check("sbc_neg", alu_result, 32'hFFFF_FFFE);
        drive(CMD_ADC, 32'h1, 32'h1, 1'b0, 12'h000, 1'b0);
        check("sbc_sr", 32'(sr_out), 32'h8);
        check("adc_c0", alu_result, 32'h2);
        drive(CMD_ORR, 32'hF0F0, 32'hFF00, 1'b0, 12'h000, 1'b0);
        check("orr", alu_result, 32'hFFF0);
        drive(CMD_EOR, 32'hF0F0, 32'hFF00, 1'b0, 12'h000, 1'b0);
        check("eor", alu_result, 32'h0FF0);
        drive(4'b1111, 32'h1, 32'h2, 1'b0, 12'h000, 1'b1);
        check("undef_res", alu_result, 32'h0);
        drive(CMD_MOV, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        check("undef_sr_kept", 32'(sr_out), 32'h8);

        // Memory address: zero-extended 12-bit offset, store data is Rm
        mem_r_en_in = 1'b1;
        drive(CMD_ADD, 32'h1000, 32'hDEAD_BEEF, 1'b0, 12'hABC, 1'b0);
        check("mem_addr", alu_result, 32'h0000_1ABC);
        check("st_val", st_val, 32'hDEAD_BEEF);
        check("mem_r_en", 32'(mem_r_en), 32'h1);
        mem_r_en_in = 1'b0;

        // Branch target with negative offset and with wrap
        b_in = 1'b1; pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE;
        drive(CMD_MOV, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        check("br_addr_neg", branch_addr, 32'h0000_00F8);
        check("br_taken", 32'(branch_taken), 32'h1);
        pc_in = 32'hFFFF_FFFC; signed_imm_24 = 24'h000001;
        drive(CMD_MOV, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        check("br_addr_wrap", branch_addr, 32'h0);
        b_in = 1'b0;

        // Forwarding of Rn from the MEM stage
        fwd_sel1 = 2'b01; mem_fwd_val = 32'd10;
        drive(CMD_ADD, 32'd100, 32'h0, 1'b1, 12'h003, 1'b0);
`ifdef EXE_FORWARDING_EN
        check("fwd_mem_rn", alu_result, 32'd13);
`else
        check("fwd_ignored_rn", alu_result, 32'd103);
`endif
        fwd_sel1 = 2'b11;
        drive(CMD_ADD, 32'd100, 32'h0, 1'b1, 12'h003, 1'b0);
        check("fwd_sel11_reg", alu_result, 32'd103);
        fwd_sel1 = 2'b00;

        // Full MUL 7*6 with S; C=1 and Z=1 are set beforehand
        drive(CMD_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 12'h000, 1'b1);
        check("add_wrap", alu_result, 32'h0);
        drive(CMD_MUL, 32'd7, 32'd6, 1'b0, 12'h000, 1'b1);
        check("pre_mul_sr", 32'(sr_out), 32'h6);
        n_stall = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!stall_out) begin
                seen_done = 1'b1;
                break;
            end
            n_stall++;
            if (i == 0 || i == 16 || i == 32) begin
                check("mul_busy_wb_en", 32'(wb_en), 32'h0);
                check("mul_busy_sr", 32'(sr_out), 32'h6);
            end
            @(negedge clk);
        end
        check("mul_done_seen", 32'(seen_done), 32'h1);
        check("mul_stall_cycles", 32'(n_stall), 32'd33);
        check("mul_result", alu_result, 32'd42);
        check("mul_done_wb_en", 32'(wb_en), 32'h1);
        drive(CMD_MOV, 32'h0, 32'h5, 1'b0, 12'h000, 1'b0);
        check("mul_sr_nz_only", 32'(sr_out), 32'h2);
        check("post_mul_stall", 32'(stall_out), 32'h0);
        check("post_mul_mov", alu_result, 32'h5);

        // Reset in the middle of a MUL
        drive(CMD_MUL, 32'd3, 32'd4, 1'b0, 12'h000, 1'b1);
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("mul_mid_stall", 32'(stall_out), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exe_cmd = CMD_MOV; val_rm = 32'h5; s_in = 1'b0;
        @(negedge clk);
        check("rst_mid_mul_stall", 32'(stall_out), 32'h0);
        check("rst_mid_mul_sr", 32'(sr_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mul_idle_stall", 32'(stall_out), 32'h0);
        check("rst_mul_idle_mov", alu_result, 32'h5);

        // Fresh MUL after reset: wrapped negative product sets N
        drive(CMD_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0, 12'h000, 1'b1);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!stall_out) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mul2_done_seen", 32'(seen_done), 32'h1);
        check("mul2_result", alu_result, 32'hFFFF_FFFE);
        drive(CMD_MOV, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        check("mul2_sr", 32'(sr_out), 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
